// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller: aligns loads/stores onto a
// word-addressed bus with byte enables, and handles the req/ack handshake, stall, misalignment and timeout.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        op_read,
  input  logic        op_write,
  input  logic [1:0]  op_size,
  input  logic [31:0] op_addr,
  input  logic [31:0] op_wdata,
  input  logic        flush,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        addr_err_ld,
  output logic        addr_err_st,
  output logic        bus_err,
  output logic [31:0] bad_vaddr,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  localparam int unsigned    CW       = $clog2(TIMEOUT_CYCLES + 2);
  localparam logic [CW-1:0]  TO_LIMIT = CW'(TIMEOUT_CYCLES);
  localparam logic           TO_EN    = (TIMEOUT_CYCLES != 0);

  logic [1:0]    state;
  logic [1:0]    state_nx;
  logic [31:0]   addr_q;
  logic [31:0]   vaddr_q;
  logic [3:0]    be_q;
  logic [31:0]   wdata_q;
  logic          we_q;
  logic [1:0]    size_q;
  logic [1:0]    lane_q;
  logic [CW-1:0] cnt;
  logic [31:0]   load_q;
  logic          berr_q;
  logic [31:0]   bad_q;

  logic          op_valid;
  logic          misaligned;
  logic          launch;
  logic          fault_now;
  logic [3:0]    lane_be;
  logic [31:0]   lane_wdata;
  logic [31:0]   rdata_shifted;
  logic [31:0]   rdata_aligned;
  logic [CW-1:0] cnt_inc;
  logic          timeout_hit;
  logic          bus_end;

  // Gating by rst_n keeps every combinational output at 0 while reset is held.
  assign op_valid = (op_read | op_write) & rst_n;

  // NOTE: every variable assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    misaligned = 1'b0;
    lane_be    = 4'hF;
    lane_wdata = op_wdata;
    case (op_size)
      SZ_HALF: begin
        misaligned = op_addr[0];
        lane_be    = 4'b0011 << op_addr[1:0];
        lane_wdata = op_wdata << {op_addr[1:0], 3'b000};
      end
      SZ_BYTE: begin
        lane_be    = 4'b0001 << op_addr[1:0];
        lane_wdata = op_wdata << {op_addr[1:0], 3'b000};
      end
      default: misaligned = (op_addr[1:0] != 2'b00);
    endcase
  end

  assign launch    = (state == S_IDLE) && op_valid && !flush && !misaligned;
  assign fault_now = (state == S_IDLE) && op_valid && !flush &&  misaligned;

  assign rdata_shifted = mem_rdata >> {lane_q, 3'b000};

  always_comb begin
    rdata_aligned = mem_rdata;
    case (size_q)
      SZ_HALF: rdata_aligned = {16'h0000, rdata_shifted[15:0]};
      SZ_BYTE: rdata_aligned = {24'h000000, rdata_shifted[7:0]};
      default: rdata_aligned = mem_rdata;
    endcase
  end

  assign cnt_inc     = cnt + 1'b1;
  assign timeout_hit = TO_EN && (cnt_inc == TO_LIMIT);
  assign bus_end     = mem_ack || timeout_hit;

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (launch) state_nx = S_REQ;
      S_REQ: begin
        if (flush)        state_nx = bus_end ? S_IDLE : S_DRAIN;
        else if (bus_end) state_nx = S_DONE;
      end
      S_DONE:  state_nx = S_IDLE;
      default: if (bus_end) state_nx = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      addr_q  <= '0;
      vaddr_q <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      size_q  <= '0;
      lane_q  <= '0;
      cnt     <= '0;
      load_q  <= '0;
      berr_q  <= 1'b0;
      bad_q   <= '0;
    end else begin
      state  <= state_nx;
      berr_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (fault_now) bad_q <= op_addr;
          if (launch) begin
            addr_q  <= {op_addr[31:2], 2'b00};
            vaddr_q <= op_addr;
            be_q    <= lane_be;
            wdata_q <= lane_wdata;
            we_q    <= op_write;
            size_q  <= op_size;
            lane_q  <= op_addr[1:0];
            cnt     <= '0;
          end
        end
        S_REQ: begin
          cnt <= cnt_inc;
          if (flush) begin
            // The drain gets a fresh timeout window for the outstanding access.
            if (!bus_end) cnt <= '0;
          end else if (mem_ack) begin
            load_q <= we_q ? 32'h0 : rdata_aligned;
          end else if (timeout_hit) begin
            load_q <= 32'h0;
            berr_q <= 1'b1;
            bad_q  <= vaddr_q;
          end
        end
        S_DRAIN: cnt <= cnt_inc;
        default: ;
      endcase
    end
  end

  always_comb begin
    stall = 1'b0;
    case (state)
      S_IDLE:  stall = launch;
      S_REQ:   stall = 1'b1;
      S_DRAIN: stall = op_valid;
      default: stall = 1'b0;
    endcase
  end

  assign mem_req     = (state == S_REQ) || (state == S_DRAIN);
  assign mem_we      = we_q;
  assign mem_addr    = addr_q;
  assign mem_be      = be_q;
  assign mem_wdata   = wdata_q;
  assign load_data   = load_q;
  assign bus_err     = berr_q;
  assign addr_err_ld = fault_now && !op_write;
  assign addr_err_st = fault_now &&  op_write;
  assign bad_vaddr   = fault_now ? op_addr : bad_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: scoreboarded bus transactions,
// misalignment, timeout, flush/drain and mid-transaction reset.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        op_read = 1'b0, op_write = 1'b0, flush = 1'b0;
  logic [1:0]  op_size = 2'b00;
  logic [31:0] op_addr = '0, op_wdata = '0;
  logic        stall, addr_err_ld, addr_err_st, bus_err;
  logic [31:0] load_data, bad_vaddr;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] load;
    logic        berr;
    logic [31:0] bad;
    int          stalls;
    int          reqs;
  } exp_t;

  exp_t exp_q[$];

  mem_access_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .op_read(op_read), .op_write(op_write), .op_size(op_size),
    .op_addr(op_addr), .op_wdata(op_wdata), .flush(flush),
    .stall(stall), .load_data(load_data),
    .addr_err_ld(addr_err_ld), .addr_err_st(addr_err_st),
    .bus_err(bus_err), .bad_vaddr(bad_vaddr),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wdata,
                              input logic we, input logic [31:0] load, input logic berr,
                              input logic [31:0] bad, input int stalls, input int reqs);
    exp_t e;
    e.addr = addr; e.be = be; e.wdata = wdata; e.we = we; e.load = load;
    e.berr = berr; e.bad = bad; e.stalls = stalls; e.reqs = reqs;
    return e;
  endfunction

  // Presents one op, answers the bus after 'waits' wait states, checks the bus
  // phase against the queue head and pops it when the DONE cycle appears.
  task automatic run_op(input string tag, input logic rd, input logic wr, input logic [1:0] size,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                        input int waits, input exp_t e);
    exp_t cur;
    int   req_n = 0, stall_n = 0, berr_n = 0;
    bit   done = 0, hdr = 0;
    cur = e;
    exp_q.push_back(e);
    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin
        op_read = rd; op_write = wr; op_size = size; op_addr = addr; op_wdata = wdata;
      end
      if (mem_req) begin
        req_n++;
        mem_ack = (req_n > waits);
      end else mem_ack = 1'b0;
      mem_rdata = mem_ack ? rdata : 32'hA5A5_A5A5;
      #1;
      if (stall) stall_n++;
      if (bus_err) berr_n++;
      if (mem_req && !hdr) begin
        hdr = 1;
        cur = exp_q[0];
        check({tag, " mem_addr"}, mem_addr, cur.addr);
        check({tag, " mem_be"}, 32'(mem_be), 32'(cur.be));
        check({tag, " mem_we"}, 32'(mem_we), 32'(cur.we));
        check({tag, " mem_wdata"}, mem_wdata, cur.wdata);
      end
      if (!stall && stall_n > 0) begin
        done = 1;
        cur = exp_q.pop_front();
        check({tag, " load_data"}, load_data, cur.load);
        check({tag, " bus_err"}, 32'(bus_err), 32'(cur.berr));
        if (cur.berr) check({tag, " bad_vaddr"}, bad_vaddr, cur.bad);
        check({tag, " stall_cycles"}, 32'(stall_n), 32'(cur.stalls));
        check({tag, " req_cycles"}, 32'(req_n), 32'(cur.reqs));
      end
    end
    if (!done) begin
      check({tag, " reached_done"}, 32'd0, 32'd1);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
    @(negedge clk);
    op_read = 1'b0; op_write = 1'b0; mem_ack = 1'b0;
    #1;
    check({tag, " idle_mem_req"}, 32'(mem_req), 32'd0);
    check({tag, " idle_stall"}, 32'(stall), 32'd0);
    check({tag, " bus_err_pulses"}, 32'(berr_n), 32'(cur.berr));
  endtask

  task automatic misaligned(input string tag, input logic rd, input logic wr, input logic [1:0] size,
                            input logic [31:0] addr, input logic exp_ld, input logic exp_st);
    @(negedge clk);
    op_read = rd; op_write = wr; op_size = size; op_addr = addr;
    #1;
    check({tag, " addr_err_ld"}, 32'(addr_err_ld), 32'(exp_ld));
    check({tag, " addr_err_st"}, 32'(addr_err_st), 32'(exp_st));
    check({tag, " bad_vaddr"}, bad_vaddr, addr);
    check({tag, " stall"}, 32'(stall), 32'd0);
    @(negedge clk);
    #1;
    check({tag, " mem_req_next"}, 32'(mem_req), 32'd0);
    op_read = 1'b0; op_write = 1'b0;
    #1;
    check({tag, " err_cleared"}, 32'(addr_err_ld | addr_err_st), 32'd0);
  endtask

  initial begin
    int berr_seen = 0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset stall", 32'(stall), 32'd0);
    check("reset mem_req", 32'(mem_req), 32'd0);
    check("reset load_data", load_data, 32'd0);
    check("reset bad_vaddr", bad_vaddr, 32'd0);
    check("reset mem_be", 32'(mem_be), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("SB", 0, 1, 2'b10, 32'h1003, 32'h0000_00AB, 32'h0, 0,
           mk(32'h1000, 4'b1000, 32'hAB00_0000, 1, 32'h0, 0, 32'h0, 2, 1));
    run_op("LH", 1, 0, 2'b01, 32'h2002, 32'h0, 32'h8765_4321, 2,
           mk(32'h2000, 4'b1100, 32'h0, 0, 32'h0000_8765, 0, 32'h0, 4, 3));
    run_op("LB", 1, 0, 2'b10, 32'h5001, 32'h0, 32'h1122_3344, 1,
           mk(32'h5000, 4'b0010, 32'h0, 0, 32'h0000_0033, 0, 32'h0, 3, 2));
    run_op("SH", 0, 1, 2'b01, 32'h6002, 32'h0000_1234, 32'h0, 0,
           mk(32'h6000, 4'b1100, 32'h1234_0000, 1, 32'h0, 0, 32'h0, 2, 1));

    misaligned("LW_mis", 1, 0, 2'b00, 32'h3001, 1, 0);
    misaligned("SH_mis", 0, 1, 2'b01, 32'h0011, 0, 1);
    misaligned("RW_mis", 1, 1, 2'b11, 32'h0002, 0, 1);

    run_op("SW_timeout", 0, 1, 2'b00, 32'h8000, 32'hCAFE_F00D, 32'h0, 1000,
           mk(32'h8000, 4'hF, 32'hCAFE_F00D, 1, 32'h0, 1, 32'h8000, 5, 4));
    run_op("LW_rsv", 1, 0, 2'b11, 32'h4000, 32'h0, 32'hDEAD_BEEF, 0,
           mk(32'h4000, 4'hF, 32'h0, 0, 32'hDEAD_BEEF, 0, 32'h0, 2, 1));

    // Flush with an aligned op in IDLE launches nothing.
    @(negedge clk);
    op_read = 1'b1; op_size = 2'b00; op_addr = 32'h0900; flush = 1'b1;
    #1;
    check("flush_idle stall", 32'(stall), 32'd0);
    @(negedge clk);
    #1;
    check("flush_idle mem_req", 32'(mem_req), 32'd0);
    op_read = 1'b0; flush = 1'b0;

    // LB flushed on its second REQ cycle, acked three cycles later.
    @(negedge clk);
    op_read = 1'b1; op_size = 2'b10; op_addr = 32'h0041;
    mem_rdata = 32'h7777_7777;
    #1;
    check("flush_lb launch_stall", 32'(stall), 32'd1);
    @(negedge clk);
    #1;
    check("flush_lb req1", 32'(mem_req), 32'd1);
    @(negedge clk);
    op_read = 1'b0; flush = 1'b1;
    #1;
    check("flush_lb req2", 32'(mem_req), 32'd1);
    berr_seen += int'(bus_err);
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("drain1 mem_req", 32'(mem_req), 32'd1);
    check("drain1 stall", 32'(stall), 32'd0);
    berr_seen += int'(bus_err);
    @(negedge clk);
    op_read = 1'b1; op_size = 2'b00; op_addr = 32'h0100;
    #1;
    check("drain2 stall_new_op", 32'(stall), 32'd1);
    berr_seen += int'(bus_err);
    @(negedge clk);
    op_read = 1'b0; mem_ack = 1'b1;
    #1;
    check("drain3 mem_req", 32'(mem_req), 32'd1);
    check("drain3 stall", 32'(stall), 32'd0);
    berr_seen += int'(bus_err);
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    check("drain_end mem_req", 32'(mem_req), 32'd0);
    check("drain_end load_data", load_data, 32'hDEAD_BEEF);
    berr_seen += int'(bus_err);
    check("drain bus_err_pulses", 32'(berr_seen), 32'd0);

    // Stray ack in IDLE is ignored.
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    check("stray_ack mem_req", 32'(mem_req), 32'd0);
    check("stray_ack load_data", load_data, 32'hDEAD_BEEF);

    // Reset asserted mid-REQ.
    @(negedge clk);
    op_write = 1'b1; op_size = 2'b00; op_addr = 32'h7000; op_wdata = 32'h0BAD_F00D;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_mid pre mem_req", 32'(mem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid mem_req", 32'(mem_req), 32'd0);
    check("rst_mid stall", 32'(stall), 32'd0);
    check("rst_mid mem_we", 32'(mem_we), 32'd0);
    check("rst_mid mem_addr", mem_addr, 32'd0);
    check("rst_mid load_data", load_data, 32'd0);
    @(negedge clk);
    op_write = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    run_op("SB_after_rst", 0, 1, 2'b10, 32'h9000, 32'h0000_005A, 32'h0, 0,
           mk(32'h9000, 4'b0001, 32'h0000_005A, 1, 32'h0, 0, 32'h0, 2, 1));

    check("scoreboard empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
